// File: rtl/pong_pkg.sv
// Shared geometry, score and state definitions for the pong game controller.
// Pure declarations: no latency, no backpressure.
package pong_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int BORDER       = 2;
    localparam int PADDLE_H     = 50;
    localparam int BALL_SIZE    = 10;
    localparam int PADDLE_STEP  = 4;
    localparam int BALL_STEP    = 2;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 9;

    // Inner faces of the paddles as drawn by the renderer
    localparam int L_PADDLE_X1  = 15;
    localparam int R_PADDLE_X0  = 620;
    localparam int L_REBOUND_X  = L_PADDLE_X1 + 1;
    localparam int R_REBOUND_X  = R_PADDLE_X0 - BALL_SIZE;

    localparam int SERVE_X      = (SCREEN_W - BALL_SIZE) / 2;
    localparam int SERVE_Y      = (SCREEN_H - BALL_SIZE) / 2;
    localparam int BALL_Y_MAX   = SCREEN_H - BORDER - BALL_SIZE;
    localparam int PADDLE_INIT  = (SCREEN_H - PADDLE_H) / 2;
    localparam int PADDLE_MIN   = BORDER;
    localparam int PADDLE_MAX   = SCREEN_H - BORDER - PADDLE_H;

    localparam int CNT_W        = $clog2(SERVE_FRAMES);

    typedef logic [9:0]         pos_t;
    typedef logic signed [10:0] coord_t;
    typedef logic [3:0]         score_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    function automatic coord_t to_coord(input int v);
        return coord_t'(v);
    endfunction

    // Screen positions are non-negative; one extra sign bit keeps arithmetic from wrapping
    function automatic coord_t widen(input pos_t p);
        return coord_t'({1'b0, p});
    endfunction

endpackage

// File: rtl/pong_game_controller_if.sv
// Control inputs and position/score buses between the game controller and the display path.
// master = game controller, slave = input source / renderer side.
interface pong_game_controller_if;
    logic       frame_tick;
    logic       start;
    logic       btn_l_up;
    logic       btn_l_dn;
    logic       btn_r_up;
    logic       btn_r_dn;
    logic [9:0] paddle_left_pos;
    logic [9:0] paddle_right_pos;
    logic [9:0] ball_pos_x;
    logic [9:0] ball_pos_y;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [1:0] game_state;
    logic       winner;

    modport master (
        input  frame_tick, start, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
        output paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y,
               score_left, score_right, game_state, winner
    );

    modport slave (
        output frame_tick, start, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
        input  paddle_left_pos, paddle_right_pos, ball_pos_x, ball_pos_y,
               score_left, score_right, game_state, winner
    );
endinterface

// File: rtl/pong_paddle_ctrl.sv
// One paddle: steps up/down by PADDLE_STEP when enabled, clamped between the walls.
// Registered position, updates the cycle after en; no backpressure.
module pong_paddle_ctrl
    import pong_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic up,
    input  logic dn,
    output pos_t pos
);

    coord_t cand;
    pos_t   nxt;

    always_comb begin
        cand = up ? widen(pos) - to_coord(PADDLE_STEP)
                  : widen(pos) + to_coord(PADDLE_STEP);
        if (cand < to_coord(PADDLE_MIN))
            nxt = pos_t'(PADDLE_MIN);
        else if (cand > to_coord(PADDLE_MAX))
            nxt = pos_t'(PADDLE_MAX);
        else
            nxt = cand[9:0];
    end

    // Both buttons or neither pressed: hold
    always_ff @(posedge clk) begin
        if (reset)
            pos <= pos_t'(PADDLE_INIT);
        else if (en && (up ^ dn))
            pos <= nxt;
    end

endmodule

// File: rtl/pong_game_controller.sv
// Per-frame pong state sequencer: paddles, ball, scores and serve/play/over flow.
// All outputs registered, updated one cycle after frame_tick (start acts without a tick); no backpressure.
module pong_game_controller
    import pong_pkg::*;
(
    input  logic clk,
    input  logic reset,
    pong_game_controller_if.master bus
);

    game_state_e      state;
    pos_t             ball_x, ball_y;
    logic             ball_dx, ball_dy;
    score_t           score_l, score_r;
    logic             winner_r;
    logic [CNT_W-1:0] serve_cnt;
    pos_t             pl, pr;
    logic             pad_en;

    coord_t bx, by, nx, ny, plc, prc;
    pos_t   ny_w;
    logic   dy_w, ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;
    score_t sl_nxt, sr_nxt;

    assign pad_en = bus.frame_tick && (state == ST_SERVE || state == ST_PLAY);

    pong_paddle_ctrl u_paddle_l (
        .clk   (clk),
        .reset (reset),
        .en    (pad_en),
        .up    (bus.btn_l_up),
        .dn    (bus.btn_l_dn),
        .pos   (pl)
    );

    pong_paddle_ctrl u_paddle_r (
        .clk   (clk),
        .reset (reset),
        .en    (pad_en),
        .up    (bus.btn_r_up),
        .dn    (bus.btn_r_dn),
        .pos   (pr)
    );

    // Collision checks use the paddle positions from before this tick's update
    always_comb begin
        bx   = widen(ball_x);
        by   = widen(ball_y);
        plc  = widen(pl);
        prc  = widen(pr);
        nx   = ball_dx ? bx + to_coord(BALL_STEP) : bx - to_coord(BALL_STEP);
        ny   = ball_dy ? by + to_coord(BALL_STEP) : by - to_coord(BALL_STEP);
        ny_w = ny[9:0];
        dy_w = ball_dy;
        if (!ball_dy && ny < to_coord(BORDER)) begin
            ny_w = pos_t'(BORDER);
            dy_w = 1'b1;
        end else if (ball_dy && ny + to_coord(BALL_SIZE) > to_coord(SCREEN_H - BORDER)) begin
            ny_w = pos_t'(BALL_Y_MAX);
            dy_w = 1'b0;
        end
        ovl_l  = (by + to_coord(BALL_SIZE) > plc) && (by < plc + to_coord(PADDLE_H));
        ovl_r  = (by + to_coord(BALL_SIZE) > prc) && (by < prc + to_coord(PADDLE_H));
        hit_l  = !ball_dx && (nx <= to_coord(L_PADDLE_X1)) && ovl_l;
        hit_r  = ball_dx && (nx + to_coord(BALL_SIZE) >= to_coord(R_PADDLE_X0)) && ovl_r;
        miss_l = !ball_dx && (nx < to_coord(0)) && !hit_l;
        miss_r = ball_dx && (nx + to_coord(BALL_SIZE) > to_coord(SCREEN_W)) && !hit_r;
        sl_nxt = score_l + 4'd1;
        sr_nxt = score_r + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ball_x    <= pos_t'(SERVE_X);
            ball_y    <= pos_t'(SERVE_Y);
            ball_dx   <= 1'b1;
            ball_dy   <= 1'b1;
            score_l   <= '0;
            score_r   <= '0;
            winner_r  <= 1'b0;
            serve_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state     <= ST_SERVE;
                        serve_cnt <= '0;
                    end
                end
                ST_SERVE: begin
                    ball_x <= pos_t'(SERVE_X);
                    ball_y <= pos_t'(SERVE_Y);
                    if (bus.frame_tick) begin
                        if (serve_cnt == CNT_W'(SERVE_FRAMES - 1))
                            state <= ST_PLAY;
                        else
                            serve_cnt <= serve_cnt + CNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (bus.frame_tick) begin
                        if (hit_l || hit_r) begin
                            ball_x  <= hit_l ? pos_t'(L_REBOUND_X) : pos_t'(R_REBOUND_X);
                            ball_dx <= hit_l;
                            ball_y  <= ny_w;
                            ball_dy <= dy_w;
                        end else if (miss_l) begin
                            score_r <= sr_nxt;
                            if (sr_nxt == score_t'(WIN_SCORE)) begin
                                state    <= ST_OVER;
                                winner_r <= 1'b1;
                            end else begin
                                state     <= ST_SERVE;
                                serve_cnt <= '0;
                                ball_x    <= pos_t'(SERVE_X);
                                ball_y    <= pos_t'(SERVE_Y);
                                ball_dx   <= 1'b0;
                            end
                        end else if (miss_r) begin
                            score_l <= sl_nxt;
                            if (sl_nxt == score_t'(WIN_SCORE)) begin
                                state    <= ST_OVER;
                                winner_r <= 1'b0;
                            end else begin
                                state     <= ST_SERVE;
                                serve_cnt <= '0;
                                ball_x    <= pos_t'(SERVE_X);
                                ball_y    <= pos_t'(SERVE_Y);
                                ball_dx   <= 1'b1;
                            end
                        end else begin
                            ball_x  <= nx[9:0];
                            ball_y  <= ny_w;
                            ball_dy <= dy_w;
                        end
                    end
                end
                ST_OVER: begin
                    if (bus.start) begin
                        state     <= ST_SERVE;
                        score_l   <= '0;
                        score_r   <= '0;
                        serve_cnt <= '0;
                        ball_x    <= pos_t'(SERVE_X);
                        ball_y    <= pos_t'(SERVE_Y);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.paddle_left_pos  = pl;
    assign bus.paddle_right_pos = pr;
    assign bus.ball_pos_x       = ball_x;
    assign bus.ball_pos_y       = ball_y;
    assign bus.score_left       = score_l;
    assign bus.score_right      = score_r;
    assign bus.game_state       = state;
    assign bus.winner           = winner_r;

endmodule

// File: tb/tb_pong_game_controller.sv
// Scoreboard bench for pong_game_controller: a behavioural game model predicts every output per cycle.
// Scripted players steer the paddles to force hits, misses, a full game and restart.
module tb_pong_game_controller;

    logic clk;
    logic reset;

    pong_game_controller_if bus ();

    pong_game_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pl, pr, bx, by, sl, sr, st, win;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    int m_state, m_pl, m_pr, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_win, m_cnt;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: dut=%0d want=%0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pl = 215; m_pr = 215; m_bx = 315; m_by = 235; m_dx = 1; m_dy = 1;
        m_sl = 0; m_sr = 0; m_state = 0; m_win = 0; m_cnt = 0;
    endtask

    function automatic int paddle_next(input int p, input bit u, input bit d);
        if (u && !d) begin
            p = p - 4;
            if (p < 2) p = 2;
        end else if (d && !u) begin
            p = p + 4;
            if (p > 428) p = 428;
        end
        return p;
    endfunction

    task automatic model_score(input bit right_scored);
        if (right_scored) m_sr++; else m_sl++;
        if ((right_scored ? m_sr : m_sl) == 9) begin
            m_state = 3;
            m_win   = right_scored ? 1 : 0;
        end else begin
            m_state = 1; m_cnt = 0; m_bx = 315; m_by = 235;
            m_dx    = right_scored ? 0 : 1;
        end
    endtask

    task automatic model_ball(input int pl, input int pr);
        int  nx, ny, ndy;
        bit  ovl_l, ovl_r;
        nx  = m_dx ? m_bx + 2 : m_bx - 2;
        ny  = m_dy ? m_by + 2 : m_by - 2;
        ndy = m_dy;
        if (m_dy == 0 && ny < 2) begin ny = 2; ndy = 1; end
        else if (m_dy == 1 && ny + 10 > 478) begin ny = 468; ndy = 0; end
        ovl_l = (m_by + 10 > pl) && (m_by < pl + 50);
        ovl_r = (m_by + 10 > pr) && (m_by < pr + 50);
        if (m_dx == 0 && nx <= 15 && ovl_l) begin
            m_bx = 16; m_dx = 1; m_by = ny; m_dy = ndy;
        end else if (m_dx == 1 && nx + 10 >= 620 && ovl_r) begin
            m_bx = 610; m_dx = 0; m_by = ny; m_dy = ndy;
        end else if (m_dx == 0 && nx < 0) begin
            model_score(1'b1);
        end else if (m_dx == 1 && nx + 10 > 640) begin
            model_score(1'b0);
        end else begin
            m_bx = nx; m_by = ny; m_dy = ndy;
        end
    endtask

    task automatic model_cycle(input bit tick, input bit st, input bit lu, input bit ld,
                               input bit ru, input bit rd);
        int pl0, pr0;
        pl0 = m_pl;
        pr0 = m_pr;
        if (tick && (m_state == 1 || m_state == 2)) begin
            m_pl = paddle_next(m_pl, lu, ld);
            m_pr = paddle_next(m_pr, ru, rd);
        end
        case (m_state)
            0: if (st) begin m_state = 1; m_cnt = 0; end
            1: if (tick) begin
                   if (m_cnt == 59) m_state = 2;
                   else m_cnt++;
               end
            2: if (tick) model_ball(pl0, pr0);
            default: if (st) begin
                   m_sl = 0; m_sr = 0; m_state = 1; m_cnt = 0; m_bx = 315; m_by = 235;
               end
        endcase
    endtask

    task automatic push_expected();
        exp_t e;
        e.pl = m_pl; e.pr = m_pr; e.bx = m_bx; e.by = m_by;
        e.sl = m_sl; e.sr = m_sr; e.st = m_state; e.win = m_win;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        check_eq("paddle_left",  int'(bus.paddle_left_pos),  e.pl);
        check_eq("paddle_right", int'(bus.paddle_right_pos), e.pr);
        check_eq("ball_x",       int'(bus.ball_pos_x),       e.bx);
        check_eq("ball_y",       int'(bus.ball_pos_y),       e.by);
        check_eq("score_left",   int'(bus.score_left),       e.sl);
        check_eq("score_right",  int'(bus.score_right),      e.sr);
        check_eq("game_state",   int'(bus.game_state),       e.st);
        check_eq("winner",       int'(bus.winner),           e.win);
    endtask

    // Inputs change #1 after a rising edge; outputs are sampled at the same offset
    task automatic drive(input bit tick, input bit st, input bit lu, input bit ld,
                         input bit ru, input bit rd);
        bus.frame_tick = tick; bus.start = st;
        bus.btn_l_up = lu; bus.btn_l_dn = ld; bus.btn_r_up = ru; bus.btn_r_dn = rd;
        model_cycle(tick, st, lu, ld, ru, rd);
        push_expected();
        @(posedge clk);
        #1;
        cyc++;
        compare_out();
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
    endtask

    task automatic paddle_dir(input int p, input int ball_c, input bit track,
                              output bit u, output bit d);
        int c;
        c = p + 25;
        u = 1'b0;
        d = 1'b0;
        if (track) begin
            u = c > ball_c + 1;
            d = c < ball_c - 1;
        end else if (ball_c < c) begin
            d = 1'b1;
        end else begin
            u = 1'b1;
        end
    endtask

    // One frame plus one idle cycle with random buttons that must have no effect
    task automatic play_tick(input bit l_track, input bit r_track, input bit st);
        bit lu, ld, ru, rd;
        paddle_dir(m_pl, m_by + 5, l_track, lu, ld);
        paddle_dir(m_pr, m_by + 5, r_track, ru, rd);
        drive(1'b1, st, lu, ld, ru, rd);
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.frame_tick = 1'b0; bus.start = 1'b0;
        bus.btn_l_up = 1'b0; bus.btn_l_dn = 1'b0; bus.btn_r_up = 1'b0; bus.btn_r_dn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        push_expected();
        compare_out();
        reset = 1'b0;

        // IDLE ignores ticks and buttons; start alone moves to SERVE
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("idle_start_serve", int'(bus.game_state), 1);

        for (int i = 0; i < 60; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            if (i == 52) check_eq("pl_after_tick53", int'(bus.paddle_left_pos), 3);
            if (i == 53) check_eq("pl_after_tick54", int'(bus.paddle_left_pos), 2);
            if (i == 58) check_eq("serve_tick59", int'(bus.game_state), 1);
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_eq("play_after_tick60", int'(bus.game_state), 2);
        check_eq("pl_clamped", int'(bus.paddle_left_pos), 2);
        check_eq("pr_both_held", int'(bus.paddle_right_pos), 215);
        check_eq("ball_parked_x", int'(bus.ball_pos_x), 315);
        check_eq("ball_parked_y", int'(bus.ball_pos_y), 235);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("tick61_x", int'(bus.ball_pos_x), 317);
        check_eq("tick61_y", int'(bus.ball_pos_y), 237);

        // Left dodges, right returns: right must score once
        n = 0;
        while (m_sr == 0 && n < 3000) begin
            play_tick(1'b0, 1'b1, (n % 37) == 0);
            n++;
        end
        check_eq("right_point", int'(bus.score_right), 1);
        check_eq("right_point_serve", int'(bus.game_state), 1);
        check_eq("right_point_bx", int'(bus.ball_pos_x), 315);

        // Left returns everything, right dodges: left wins 9-1
        n = 0;
        while (m_state != 3 && n < 15000) begin
            play_tick(1'b1, 1'b0, (n % 41) == 0);
            n++;
        end
        check_eq("game_over", int'(bus.game_state), 3);
        check_eq("winner_left", int'(bus.winner), 0);
        check_eq("final_left", int'(bus.score_left), 9);

        repeat (5) play_tick(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("restart_serve", int'(bus.game_state), 1);
        check_eq("restart_score_l", int'(bus.score_left), 0);

        repeat (70) play_tick(1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        model_reset();
        push_expected();
        @(posedge clk);
        #1;
        compare_out();
        check_eq("midgame_reset_idle", int'(bus.game_state), 0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
